// File: rtl/frame_filter_pkg.sv
`default_nettype none
// ============================================================================
// frame_filter_pkg : shared constants and helpers for the frame-filter path
// Revision: 1.0
// ============================================================================
package frame_filter_pkg;

    localparam int SOF_BIT    = 0;
    localparam int DATA_W_DEF = 4;
    localparam int USER_W_DEF = 2;

    // Maps a requested replication factor onto the legal range 1..max_factor.
    function automatic int clamp_factor(input int factor, input int max_factor);
        if (factor < 1) begin
            return 1;
        end
        if (factor > max_factor) begin
            return max_factor;
        end
        return factor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_hold_reg.sv
`default_nettype none
// ============================================================================
// stream_hold_reg : one-entry data/user/last holding register
// Revision: 1.0
// ============================================================================
module stream_hold_reg #(
    parameter int DATA_W = 4,
    parameter int USER_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [USER_W-1:0] load_user,
    input  logic              load_last,
    output logic [DATA_W-1:0] hold_data,
    output logic [USER_W-1:0] hold_user,
    output logic              hold_last
);

    // Load wins over clear so a back-to-back beat is never dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            hold_user <= '0;
            hold_last <= 1'b0;
        end else if (load) begin
            hold_data <= load_data;
            hold_user <= load_user;
            hold_last <= load_last;
        end else if (clear) begin
            hold_data <= '0;
            hold_user <= '0;
            hold_last <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_replicator.sv
`default_nettype none
// ============================================================================
// stream_replicator : emits every accepted AXI-Stream beat FACTOR times
// Revision: 1.0
// ============================================================================
module stream_replicator
    import frame_filter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int USER_W     = USER_W_DEF,
    parameter int MAX_FACTOR = 8,
    parameter int FW         = $clog2(MAX_FACTOR + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FW-1:0]     i_factor,
    input  logic [DATA_W-1:0] i_TDATA,
    input  logic              i_TVALID,
    input  logic [USER_W-1:0] i_TUSER,
    input  logic              i_TLAST,
    output logic              o_TREADY,
    output logic [DATA_W-1:0] o_TDATA,
    output logic              o_TVALID,
    output logic [USER_W-1:0] o_TUSER,
    output logic              o_TLAST,
    input  logic              i_TREADY,
    output logic              o_busy
);

    localparam logic [0:0] S_EMPTY  = 1'b0;
    localparam logic [0:0] S_REPLAY = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [FW-1:0]     cnt;
    logic [FW-1:0]     fac;
    logic [FW-1:0]     fac_m1;
    logic [FW-1:0]     fac_req;
    logic              busy;
    logic              last_copy;
    logic              consume;
    logic              accept;
    logic              ready;
    logic [DATA_W-1:0] hold_data;
    logic [USER_W-1:0] hold_user;
    logic              hold_last;

    assign fac_m1    = fac - FW'(1);
    assign last_copy = (cnt == fac_m1);
    assign consume   = (state == S_REPLAY) && i_TREADY && last_copy;
    assign ready     = (state == S_EMPTY) || consume;
    assign accept    = i_TVALID && ready;
    assign fac_req   = FW'(clamp_factor(int'(i_factor), MAX_FACTOR));

    stream_hold_reg #(
        .DATA_W (DATA_W),
        .USER_W (USER_W)
    ) u_hold (
        .clk       (clk),
        .rst       (reset),
        .load      (accept),
        .clear     (consume && !i_TVALID),
        .load_data (i_TDATA),
        .load_user (i_TUSER),
        .load_last (i_TLAST),
        .hold_data (hold_data),
        .hold_user (hold_user),
        .hold_last (hold_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: begin
                if (i_TVALID) begin
                    state_nxt = S_REPLAY;
                end
            end
            S_REPLAY: begin
                if (consume && !i_TVALID) begin
                    state_nxt = S_EMPTY;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // Factor is only sampled on a SOF beat so a frame keeps one replication rate.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            fac  <= FW'(1);
            busy <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= '0;
                if (i_TUSER[SOF_BIT]) begin
                    fac <= fac_req;
                end
            end else if ((state == S_REPLAY) && i_TREADY && !last_copy) begin
                cnt <= cnt + FW'(1);
            end

            if (accept && i_TUSER[SOF_BIT]) begin
                busy <= 1'b1;
            end else if (consume && hold_last) begin
                busy <= 1'b0;
            end
        end
    end

    always_comb begin
        o_TREADY = ready;
        o_TVALID = (state == S_REPLAY);
        o_TDATA  = hold_data;
        o_TUSER  = hold_user;
        if (cnt != '0) begin
            o_TUSER[SOF_BIT] = 1'b0;
        end
        o_TLAST  = (state == S_REPLAY) && hold_last && last_copy;
        o_busy   = busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_replicator.sv
`default_nettype none
// ============================================================================
// tb_stream_replicator : scoreboard bench for stream_replicator
// Revision: 1.0
// ============================================================================
module tb_stream_replicator;

    localparam int DATA_W     = 4;
    localparam int USER_W     = 2;
    localparam int MAX_FACTOR = 8;
    localparam int FW         = $clog2(MAX_FACTOR + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [USER_W-1:0] user;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [FW-1:0]     i_factor;
    logic [DATA_W-1:0] i_TDATA;
    logic              i_TVALID;
    logic [USER_W-1:0] i_TUSER;
    logic              i_TLAST;
    logic              o_TREADY;
    logic [DATA_W-1:0] o_TDATA;
    logic              o_TVALID;
    logic [USER_W-1:0] o_TUSER;
    logic              o_TLAST;
    logic              i_TREADY;
    logic              o_busy;

    int    compared   = 0;
    int    mismatched = 0;
    int    out_count  = 0;
    int    model_fac  = 1;
    int    ready_mode = 0;
    bit    gaps       = 0;
    bit    abort      = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    stream_replicator #(
        .DATA_W     (DATA_W),
        .USER_W     (USER_W),
        .MAX_FACTOR (MAX_FACTOR),
        .FW         (FW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_factor (i_factor),
        .i_TDATA  (i_TDATA),
        .i_TVALID (i_TVALID),
        .i_TUSER  (i_TUSER),
        .i_TLAST  (i_TLAST),
        .o_TREADY (o_TREADY),
        .o_TDATA  (o_TDATA),
        .o_TVALID (o_TVALID),
        .o_TUSER  (o_TUSER),
        .o_TLAST  (o_TLAST),
        .i_TREADY (i_TREADY),
        .o_busy   (o_busy)
    );

    function automatic int ref_factor(input int req);
        if (req == 0) return 1;
        if (req > MAX_FACTOR) return MAX_FACTOR;
        return req;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready pattern: 0 = always ready, 1 = toggling, 2 = random.
    initial begin
        i_TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       i_TREADY = ~i_TREADY;
                2:       i_TREADY = ($urandom_range(0, 3) != 0);
                default: i_TREADY = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every downstream handshake.
    beat_t stall_val;
    beat_t got;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(o_TVALID), 32'd1);
                check("stall_data",  32'(o_TDATA),  32'(stall_val.data));
                check("stall_user",  32'(o_TUSER),  32'(stall_val.user));
                check("stall_last",  32'(o_TLAST),  32'(stall_val.last));
            end
            stalled = 1'b0;
            if (o_TVALID) begin
                check("busy_in_frame", 32'(o_busy), 32'd1);
                if (i_TREADY) begin
                    out_count++;
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_beat: got data %0h with empty scoreboard at %0t", o_TDATA, $time);
                    end else begin
                        got = exp_q.pop_front();
                        check("out_data", 32'(o_TDATA), 32'(got.data));
                        check("out_user", 32'(o_TUSER), 32'(got.user));
                        check("out_last", 32'(o_TLAST), 32'(got.last));
                    end
                end else begin
                    stalled        = 1'b1;
                    stall_val.data = o_TDATA;
                    stall_val.user = o_TUSER;
                    stall_val.last = o_TLAST;
                end
            end
        end
    end

    // Presents one beat; on acceptance pushes its expected copies.
    task automatic drive_beat(input logic [DATA_W-1:0] d, input logic [USER_W-1:0] u, input logic l);
        bit acc;
        int guard = 0;
        i_TVALID = 1'b1;
        i_TDATA  = d;
        i_TUSER  = u;
        i_TLAST  = l;
        forever begin
            @(negedge clk);
            acc = o_TREADY && !abort;
            if (acc) begin
                if (u[0]) model_fac = ref_factor(int'(i_factor));
                for (int k = 0; k < model_fac; k++) begin
                    beat_t b;
                    b.data = d;
                    b.user = u;
                    if (k != 0) b.user[0] = 1'b0;
                    b.last = l && (k == model_fac - 1);
                    exp_q.push_back(b);
                end
            end
            @(posedge clk);
            #1;
            if (acc || abort) break;
            guard++;
            if (guard > 200) begin
                compared++;
                mismatched++;
                $display("FAIL accept_timeout: got no o_TREADY in %0d cycles, expected acceptance", guard);
                break;
            end
        end
        i_TVALID = 1'b0;
    endtask

    task automatic send_frame(input int n, input int f, input int chg_at, input int new_f, input bit rnd);
        logic [DATA_W-1:0] d;
        logic [USER_W-1:0] u;
        i_factor = FW'(f);
        for (int k = 1; k <= n; k++) begin
            if (abort) break;
            if (chg_at > 0 && k == chg_at + 1) i_factor = FW'(new_f);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            d = rnd ? DATA_W'($urandom) : DATA_W'(k);
            u = {1'($urandom_range(0, 1)), 1'(k == 1)};
            drive_beat(d, u, k == n);
        end
    endtask

    task automatic drain_and_count(input string name, input int base, input int exp_total);
        int g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check({name, "_count"}, 32'(out_count - base), 32'(exp_total));
        check({name, "_idle_busy"}, 32'(o_busy), 32'd0);
        check({name, "_idle_valid"}, 32'(o_TVALID), 32'd0);
    endtask

    task automatic run_frame(input string name, input int n, input int f, input int chg_at,
                             input int new_f, input bit rnd, input int mode);
        int base;
        base       = out_count;
        ready_mode = mode;
        send_frame(n, f, chg_at, new_f, rnd);
        drain_and_count(name, base, n * ref_factor(f));
    endtask

    initial begin
        int base;
        reset    = 1'b1;
        i_factor = FW'(1);
        i_TDATA  = '0;
        i_TVALID = 1'b0;
        i_TUSER  = '0;
        i_TLAST  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_valid", 32'(o_TVALID), 32'd0);
        check("rst_data",  32'(o_TDATA),  32'd0);
        check("rst_user",  32'(o_TUSER),  32'd0);
        check("rst_last",  32'(o_TLAST),  32'd0);
        check("rst_busy",  32'(o_busy),   32'd0);
        check("rst_ready", 32'(o_TREADY), 32'd1);

        run_frame("f1",    10, 1,  0, 0, 1'b0, 0);
        run_frame("f2",    10, 2,  0, 0, 1'b0, 0);
        run_frame("f3tog", 10, 3,  0, 0, 1'b0, 1);
        run_frame("chg",   10, 2,  3, 4, 1'b0, 0);
        run_frame("next4", 10, 4,  0, 0, 1'b0, 0);
        run_frame("f0",    10, 0,  0, 0, 1'b0, 0);
        run_frame("f15",   10, 15, 0, 0, 1'b0, 2);

        // Reset while the second copy of beat 5 is on the output at FACTOR=3.
        ready_mode = 0;
        base       = out_count;
        fork
            send_frame(10, 3, 0, 0, 1'b0);
            begin
                int g = 0;
                while (out_count - base < 13 && g < 500) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                check("mid_reach", 32'(out_count - base), 32'd13);
                abort = 1'b1;
                reset = 1'b1;
                @(posedge clk);
                #1;
                check("mid_rst_valid", 32'(o_TVALID), 32'd0);
                check("mid_rst_busy",  32'(o_busy),   32'd0);
                check("mid_rst_ready", 32'(o_TREADY), 32'd1);
                check("mid_rst_last",  32'(o_TLAST),  32'd0);
            end
        join
        exp_q.delete();
        model_fac = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        abort = 1'b0;
        run_frame("post_rst", 10, 3, 0, 0, 1'b0, 0);

        gaps = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_frame("rand", $urandom_range(1, 6), $urandom_range(0, 15),
                      $urandom_range(0, 3), $urandom_range(0, 15), 1'b1, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
